// File: rtl/fpga_pkg.sv
// Shared definitions for the FPGA reset sequencer.
//   seq_state_e : sequencer FSM encoding, also exported on the debug state port
//   EVENT_W     : width of the saturating reset-event counter
//   cnt_width() : counter width helper, $clog2(n) with a 1-bit floor
package fpga_pkg;

  localparam int EVENT_W = 8;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    HOLD       = 3'd1,
    REL_PERIPH = 3'd2,
    RUN        = 3'd3
  } seq_state_e;

  // A counter of this width holds 0 .. n-1, which is all the terminal
  // compares below ever need.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpga_reset_seq_if.sv
// Board-side / SoC-side signal bundle of the reset sequencer.
//   pll_locked   : PLL lock, asynchronous to clk
//   btn_rst_n    : board reset button, active low, asynchronous and bouncy
//   rst_n_periph : active-low reset for bus fabric and peripherals
//   rst_n_core   : active-low reset for processor and debug
//   state        : current sequencer state (seq_state_e encoding)
//   event_count  : saturating count of reset events since rst_n
// There is no handshake: the inputs are level signals sampled every cycle
// through synchronisers, the outputs are registered levels.
// master = the sequencer, slave = the board/SoC side.
interface fpga_reset_seq_if;
  import fpga_pkg::*;

  logic               pll_locked;
  logic               btn_rst_n;
  logic               rst_n_periph;
  logic               rst_n_core;
  logic [2:0]         state;
  logic [EVENT_W-1:0] event_count;

  modport master (
    input  pll_locked,
    input  btn_rst_n,
    output rst_n_periph,
    output rst_n_core,
    output state,
    output event_count
  );

  modport slave (
    output pll_locked,
    output btn_rst_n,
    input  rst_n_periph,
    input  rst_n_core,
    input  state,
    input  event_count
  );

endinterface

// File: rtl/fpga_sync_bit.sv
// N-flop synchroniser for one asynchronous level input.
//   clk, rst_n : clock, asynchronous active-low reset (flops clear to 0)
//   d_i        : asynchronous input
//   q_o        : synchronised output, N clk edges of latency
// N must be at least 2.
module fpga_sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/fpga_reset_seq.sv
// Reset sequencer between the PLL/board inputs and the SoC.
//   clk, rst_n : system clock, asynchronous active-low power-on reset
//   bus        : fpga_reset_seq_if.master (lock/button in, resets/debug out)
// Lock is qualified by LOCK_STABLE_CYCLES consecutive good samples, then
// both resets are held HOLD_CYCLES more, rst_n_periph is released, and
// rst_n_core follows CORE_DELAY cycles later. Lock loss or a debounced
// button press outside WAIT_LOCK drops both resets on the next edge and
// counts one reset event.
module fpga_reset_seq
  import fpga_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 16,
  parameter int CORE_DELAY         = 8,
  parameter int DEBOUNCE_CYCLES    = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  fpga_reset_seq_if.master bus
);

  localparam int LW  = cnt_width(LOCK_STABLE_CYCLES);
  localparam int HW  = cnt_width(HOLD_CYCLES);
  localparam int CW  = cnt_width(CORE_DELAY);
  localparam int SW  = (HW > CW) ? HW : CW;
  localparam int DW  = cnt_width(DEBOUNCE_CYCLES);

  localparam logic [LW-1:0]      LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [SW-1:0]      HOLD_LAST = SW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0]      CORE_LAST = SW'(CORE_DELAY - 1);
  localparam logic [DW-1:0]      BTN_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [EVENT_W-1:0] EVT_MAX   = '1;

  logic lock_s;
  logic btn_s;

  fpga_sync_bit #(.N(SYNC_STAGES)) u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.pll_locked),
    .q_o   (lock_s)
  );

  fpga_sync_bit #(.N(SYNC_STAGES)) u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.btn_rst_n),
    .q_o   (btn_s)
  );

  seq_state_e         state_q,    state_d;
  logic [LW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [SW-1:0]      seq_cnt_q,  seq_cnt_d;
  logic [DW-1:0]      btn_cnt_q,  btn_cnt_d;
  logic               periph_q,   periph_d;
  logic               core_q,     core_d;
  logic [EVENT_W-1:0] event_q,    event_d;

  logic btn_press;
  logic abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      seq_cnt_q  <= '0;
      btn_cnt_q  <= '0;
      periph_q   <= 1'b0;
      core_q     <= 1'b0;
      event_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      seq_cnt_q  <= seq_cnt_d;
      btn_cnt_q  <= btn_cnt_d;
      periph_q   <= periph_d;
      core_q     <= core_d;
      event_q    <= event_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    seq_cnt_d  = seq_cnt_q;
    btn_cnt_d  = btn_cnt_q;
    periph_d   = periph_q;
    core_d     = core_q;
    event_d    = event_q;

    // Debounce: the counter parks at BTN_LAST while the button stays low,
    // so a long hold is a single press.
    if (btn_s) begin
      btn_cnt_d = '0;
    end else if (btn_cnt_q != BTN_LAST) begin
      btn_cnt_d = btn_cnt_q + DW'(1);
    end
    btn_press = !btn_s && (btn_cnt_q == BTN_LAST);

    // Lock loss is unfiltered once the sequence has started; a press and a
    // lock loss on the same edge are one event.
    abort = (state_q != WAIT_LOCK) && (!lock_s || btn_press);

    case (state_q)
      WAIT_LOCK: begin
        periph_d = 1'b0;
        core_d   = 1'b0;
        if (lock_s && btn_s) begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d    = HOLD;
            lock_cnt_d = '0;
            seq_cnt_d  = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LW'(1);
          end
        end else begin
          lock_cnt_d = '0;
        end
      end
      HOLD: begin
        if (seq_cnt_q == HOLD_LAST) begin
          state_d   = REL_PERIPH;
          seq_cnt_d = '0;
          periph_d  = 1'b1;
        end else begin
          seq_cnt_d = seq_cnt_q + SW'(1);
        end
      end
      REL_PERIPH: begin
        if (seq_cnt_q == CORE_LAST) begin
          state_d   = RUN;
          seq_cnt_d = '0;
          core_d    = 1'b1;
        end else begin
          seq_cnt_d = seq_cnt_q + SW'(1);
        end
      end
      RUN: begin
      end
      default: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
        seq_cnt_d  = '0;
        periph_d   = 1'b0;
        core_d     = 1'b0;
      end
    endcase

    if (abort) begin
      state_d    = WAIT_LOCK;
      lock_cnt_d = '0;
      seq_cnt_d  = '0;
      periph_d   = 1'b0;
      core_d     = 1'b0;
      if (event_q != EVT_MAX) begin
        event_d = event_q + EVENT_W'(1);
      end
    end
  end

  assign bus.rst_n_periph = periph_q;
  assign bus.rst_n_core   = core_q;
  assign bus.state        = state_q;
  assign bus.event_count  = event_q;

endmodule
